// File: rtl/fifo_write_sync_pkg.sv
// Shared UART/IrDA definitions for the receive-to-FIFO write path: defaults,
// FSM encodings and small sizing helpers.
package fifo_write_sync_pkg;

    localparam int unsigned DataWidthDef   = 8;
    localparam int unsigned StallMaxDef    = 1023;
    localparam int unsigned DropCountWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'b01,
        StWrite = 2'b10
    } state_e;

    // Bits needed to hold 0..max_count; never narrower than one bit.
    function automatic int unsigned stall_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/fifo_write_sync_if.sv
// Receiver/FIFO-side bundle of the write synchroniser; master is the block
// itself, slave is the surrounding receiver, FIFO and status logic.
interface fifo_write_sync_if
    import fifo_write_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef
);

    logic                      rx_done;
    logic [DATA_WIDTH-1:0]     rx_data;
    logic                      frame_err;
    logic                      full;
    logic                      ovf_clr;
    logic                      wr_data;
    logic [DATA_WIDTH-1:0]     din;
    logic                      busy;
    logic                      overflow;
    logic [DropCountWidth-1:0] drop_count;

    modport master (
        input  rx_done, rx_data, frame_err, full, ovf_clr,
        output wr_data, din, busy, overflow, drop_count
    );

    modport slave (
        output rx_done, rx_data, frame_err, full, ovf_clr,
        input  wr_data, din, busy, overflow, drop_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same cycle
// as a clear leaves the count at one.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_write_sync.sv
// Turns receiver rx_done pulses into single FIFO write strobes, holding one
// character across FIFO-full stalls and accounting for every lost character.
module fifo_write_sync
    import fifo_write_sync_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef,
    parameter int unsigned STALL_MAX  = StallMaxDef
) (
    input  logic          clock,
    input  logic          reset,
    fifo_write_sync_if.master bus
);

    localparam int unsigned StallW = stall_width(STALL_MAX);
    localparam logic [StallW-1:0] StallLast = StallW'(STALL_MAX - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [StallW-1:0]     stall_q, stall_d;
    logic                  overflow_q, overflow_d;
    logic                  good_char;
    logic                  bad_char;
    logic                  lost;
    logic                  drop_inc;

    assign good_char = bus.rx_done & ~bus.frame_err;
    assign bad_char  = bus.rx_done &  bus.frame_err;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stall_d = stall_q;
        lost    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (good_char) begin
                    hold_d  = bus.rx_data;
                    stall_d = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!bus.full) begin
                    // Pending character is written this cycle; a new one chains behind it.
                    if (good_char) begin
                        hold_d  = bus.rx_data;
                        stall_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (good_char) begin
                        lost = 1'b1;
                    end
                    if (stall_q == StallLast) begin
                        lost    = 1'b1;
                        stall_d = '0;
                        state_d = StIdle;
                    end else begin
                        stall_d = stall_q + StallW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (lost) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            stall_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame errors and losses share one increment, so coincident causes count once.
    assign drop_inc = bad_char | lost;

    sat_counter #(
        .WIDTH(DropCountWidth)
    ) u_drop_count (
        .clock(clock),
        .reset(reset),
        .inc  (drop_inc),
        .clr  (bus.ovf_clr),
        .count(bus.drop_count)
    );

    assign bus.wr_data  = (state_q == StWrite) & ~bus.full;
    assign bus.busy     = (state_q == StWrite);
    assign bus.din      = hold_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fifo_write_sync.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// cycle by cycle against a pending-character reference model.
module tb_fifo_write_sync;

    localparam int unsigned TbStallMax = 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    // Reference model state.
    logic [7:0] pending[$];
    logic [7:0] m_hold;
    int         m_stall;
    int         m_cnt;
    logic       m_ovf;

    fifo_write_sync_if #(.DATA_WIDTH(8)) bus ();

    fifo_write_sync #(
        .DATA_WIDTH(8),
        .STALL_MAX (TbStallMax)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        m_hold  = '0;
        m_stall = 0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic rxd, input logic [7:0] data, input logic fe,
                              input logic fl, input logic clr);
        logic good;
        logic lost;
        logic inc;
        good = rxd && !fe;
        lost = 1'b0;
        inc  = rxd && fe;
        if (pending.size() != 0) begin
            if (!fl) begin
                void'(pending.pop_front());
                if (good) begin
                    pending.push_back(data);
                    m_hold  = data;
                    m_stall = 0;
                end
            end else begin
                if (good) lost = 1'b1;
                m_stall++;
                if (m_stall >= TbStallMax) begin
                    lost = 1'b1;
                    pending.delete();
                    m_stall = 0;
                end
            end
        end else if (good) begin
            pending.push_back(data);
            m_hold  = data;
            m_stall = 0;
        end
        if (lost) inc = 1'b1;
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        if (inc && m_cnt < 255) m_cnt++;
        if (lost) m_ovf = 1'b1;
    endtask

    // Apply inputs for one cycle, compare outputs mid-cycle, then advance the model.
    task automatic step(input logic rxd, input logic [7:0] data, input logic fe,
                        input logic fl, input logic clr);
        bus.rx_done   = rxd;
        bus.rx_data   = data;
        bus.frame_err = fe;
        bus.full      = fl;
        bus.ovf_clr   = clr;
        #1;
        check_eq("wr_data", bus.wr_data, (pending.size() != 0) && !fl);
        check_eq("din", bus.din, m_hold);
        check_eq("busy", bus.busy, pending.size() != 0);
        check_eq("overflow", bus.overflow, m_ovf);
        check_eq("drop_count", bus.drop_count, m_cnt);
        @(posedge clock);
        model_edge(rxd, data, fe, fl, clr);
        #1;
    endtask

    initial begin
        logic fl;
        n_checks = 0;
        n_errors = 0;
        reset         = 1'b0;
        bus.rx_done   = 1'b0;
        bus.rx_data   = '0;
        bus.frame_err = 1'b0;
        bus.full      = 1'b0;
        bus.ovf_clr   = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        check_eq("rst_wr_data", bus.wr_data, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_din", bus.din, 0);
        check_eq("rst_overflow", bus.overflow, 0);
        check_eq("rst_drop_count", bus.drop_count, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single character, one-cycle latency.
        step(1, 8'hA5, 0, 0, 0);
        check_eq("a5_wr", bus.wr_data, 1);
        check_eq("a5_din", bus.din, 8'hA5);
        step(0, 8'h00, 0, 0, 0);
        check_eq("a5_idle", bus.busy, 0);
        check_eq("a5_once", bus.wr_data, 0);

        // Back-to-back characters.
        step(1, 8'h11, 0, 0, 0);
        check_eq("b2b_wr1", bus.wr_data, 1);
        check_eq("b2b_din1", bus.din, 8'h11);
        step(1, 8'h22, 0, 0, 0);
        check_eq("b2b_wr2", bus.wr_data, 1);
        check_eq("b2b_din2", bus.din, 8'h22);
        step(0, 8'h00, 0, 0, 0);
        check_eq("b2b_done", bus.wr_data, 0);

        // New character while full is dropped, pending one survives.
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h33, 0, 1, 0);
        check_eq("full_nowr", bus.wr_data, 0);
        step(1, 8'h44, 0, 1, 0);
        check_eq("full_ovf", bus.overflow, 1);
        check_eq("full_cnt", bus.drop_count, 1);
        bus.full = 1'b0;
        #1;
        check_eq("full_wr33", bus.wr_data, 1);
        check_eq("full_din33", bus.din, 8'h33);
        step(0, 8'h00, 0, 0, 0);
        check_eq("full_single", bus.wr_data, 0);

        // Stall timeout drops the pending character.
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h55, 0, 1, 0);
        repeat (TbStallMax) step(0, 8'h00, 0, 1, 0);
        check_eq("stall_idle", bus.busy, 0);
        check_eq("stall_ovf", bus.overflow, 1);
        check_eq("stall_cnt", bus.drop_count, 1);
        step(0, 8'h00, 0, 0, 0);
        check_eq("stall_nowr", bus.wr_data, 0);

        // Frame errors count without overflow, then saturate.
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h66, 1, 0, 0);
        check_eq("fe_nowr", bus.wr_data, 0);
        check_eq("fe_cnt", bus.drop_count, 1);
        check_eq("fe_ovf", bus.overflow, 0);
        repeat (299) step(1, 8'h66, 1, 0, 0);
        check_eq("fe_sat", bus.drop_count, 255);
        step(1, 8'h66, 1, 0, 1);
        check_eq("clr_inc_cnt", bus.drop_count, 1);

        // Asynchronous reset while a character is pending.
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h77, 0, 1, 0);
        bus.rx_done = 1'b0;
        bus.full    = 1'b0;
        #1;
        check_eq("pre_rst_wr", bus.wr_data, 1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_eq("arst_wr", bus.wr_data, 0);
        check_eq("arst_busy", bus.busy, 0);
        check_eq("arst_din", bus.din, 0);
        check_eq("arst_ovf", bus.overflow, 0);
        check_eq("arst_cnt", bus.drop_count, 0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check_eq("post_rst_nowr", bus.wr_data, 0);

        // Randomized traffic with bursty full.
        fl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) fl = ~fl;
            step(($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 9) == 0), fl,
                 ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_sync.md
FIFO_WRITE_SYNC -- requirements
Module: fifo_write_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, received character width.
REQ-002 SHALL have parameter STALL_MAX, default 1023, max cycles a pending character waits on full before being dropped.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_done  input  1  one-cycle pulse: receiver has a complete character on rx_data.
REQ-006 SHALL have port rx_data  input  DATA_WIDTH  received character, valid only when rx_done=1.
REQ-007 SHALL have port frame_err  input  1  qualifies rx_done: character has a stop-bit/frame error.
REQ-008 SHALL have port full  input  1  FIFO cannot accept a write this cycle.
REQ-009 SHALL have port ovf_clr  input  1  one-cycle pulse clearing overflow and drop_count.
REQ-010 SHALL have port wr_data  output  1  FIFO write strobe, one cycle per character.
REQ-011 SHALL have port din  output  DATA_WIDTH  character presented to FIFO, valid when wr_data=1.
REQ-012 SHALL have port busy  output  1  a character is pending (state WRITE).
REQ-013 SHALL have port overflow  output  1  sticky: at least one good character was lost.
REQ-014 SHALL have port drop_count  output  8  saturating count of lost or frame-errored characters.

Function
REQ-015 SHALL implement a one-hot FSM with states IDLE=2'b01 and WRITE=2'b10; illegal encodings return to IDLE next cycle.
REQ-016 SHALL, in IDLE on rx_done=1 and frame_err=0, latch rx_data into the hold register, clear the stall counter, and move to WRITE.
REQ-017 SHALL, on rx_done=1 with frame_err=1 in any state, discard the character, increment drop_count, and leave overflow unchanged.
REQ-018 SHALL drive wr_data combinationally as (state==WRITE) and full=0; din SHALL equal the hold register at all times.
REQ-019 SHALL give latency of exactly one cycle: rx_done at edge N yields wr_data high during cycle N+1 when full=0.
REQ-020 SHALL, in WRITE with full=0 and no new good rx_done, return to IDLE after the write.
REQ-021 SHALL, in WRITE with full=0 and simultaneous good rx_done, write the pending character, latch the new one, and stay in WRITE (back-to-back, no loss).
REQ-022 SHALL, in WRITE with full=1 and a new good rx_done, keep the pending character, drop the new one, set overflow, and increment drop_count.
REQ-023 SHALL, in WRITE with full=1, increment the stall counter each cycle; on reaching STALL_MAX it SHALL drop the pending character, set overflow, increment drop_count, and go to IDLE.
REQ-024 SHALL saturate drop_count at 255; a second increment source in the same cycle SHALL still add only one.
REQ-025 SHALL clear overflow and drop_count on ovf_clr; an increment in the same cycle SHALL win (count=1, overflow set if the cause is a loss).
REQ-026 SHALL never assert wr_data while full=1 and never write a character twice.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, hold register 0, stall counter 0, wr_data 0, busy 0, overflow 0, drop_count 0, independent of clock.
REQ-028 SHALL discard any pending character when reset asserts mid-operation; first write after release requires a new rx_done.

Structure
REQ-029 SHALL take state encodings, DATA_WIDTH default, and STALL_MAX default from the shared UART/IrDA package.
REQ-030 SHALL instantiate one sub-module, sat_counter (8-bit saturating counter with inc and clr), for drop_count.

Verification
REQ-031 SHALL verify: rx_done with rx_data=8'hA5, full=0 -> wr_data=1 next cycle only, din=8'hA5, then IDLE.
REQ-032 SHALL verify: rx_done 8'h11 and 8'h22 on consecutive cycles, full=0 -> two consecutive wr_data pulses, din 8'h11 then 8'h22.
REQ-033 SHALL verify: full=1, rx_done 8'h33 then 8'h44 -> no write, overflow=1, drop_count=1; full=0 -> single write of 8'h33.
REQ-034 SHALL verify: STALL_MAX=4, full held 1 after rx_done 8'h55 -> after 4 cycles IDLE, overflow=1, drop_count=1, 8'h55 never written.
REQ-035 SHALL verify: rx_done with frame_err=1 -> no write, drop_count=1, overflow=0; 300 such events -> drop_count=255.
REQ-036 SHALL verify: reset=0 asserted in WRITE between clock edges -> outputs 0 immediately; after release, no write without new rx_done.
